// File: rtl/reg_access_arbiter.sv
// ----------------------------------------------------------------------------
// reg_access_arbiter
//
// Two-requester round-robin arbiter in front of a single shared register
// block. Requester 0 is the CPU (AXI-Lite side) and requester 1 is the internal
// poller. Only one access is outstanding at a time. The flow is
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Optional feature macro: REG_ARB_TIMEOUT_EN
//   When it is defined, a WAIT-state counter abandons a silent bus access after
//   TIMEOUT_CYCLES cycles. The response then carries 32'hFEE1DEAD (replicated)
//   with err=1.
//   When it is undefined, WAIT waits forever and mN_rsp_err is tied to 0.
//
// Ports
//   clk, reset                  single clock, synchronous active-high reset
//   mN_req_valid/ready          request handshake; ready is combinational
//   mN_req_addr/wr/wdata/wstrb  request fields, latched on accept
//   mN_rsp_valid                one-cycle response pulse
//   mN_rsp_rdata/err            response data/error, held between responses
//   bus_req_valid               one-cycle issue pulse to the register block
//   bus_req_addr/wr/wdata/wstrb latched fields, stable until back in IDLE
//   bus_rsp_valid/rdata         completion from the register block
// ----------------------------------------------------------------------------
module reg_access_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_req_addr,
    input  logic                    m0_req_wr,
    input  logic [DATA_WIDTH-1:0]   m0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_req_wstrb,
    output logic                    m0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m0_rsp_rdata,
    output logic                    m0_rsp_err,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_req_addr,
    input  logic                    m1_req_wr,
    input  logic [DATA_WIDTH-1:0]   m1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_req_wstrb,
    output logic                    m1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m1_rsp_rdata,
    output logic                    m1_rsp_err,

    output logic                    bus_req_valid,
    output logic [ADDR_WIDTH-1:0]   bus_req_addr,
    output logic                    bus_req_wr,
    output logic [DATA_WIDTH-1:0]   bus_req_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_req_wstrb,
    input  logic                    bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   bus_rsp_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e                  state_q;
    logic                    last_grant_q;
    logic                    grant_q;
    logic                    bus_req_valid_q;
    logic [ADDR_WIDTH-1:0]   bus_addr_q;
    logic                    bus_wr_q;
    logic [DATA_WIDTH-1:0]   bus_wdata_q;
    logic [DATA_WIDTH/8-1:0] bus_wstrb_q;
    logic                    m0_rsp_valid_q, m1_rsp_valid_q;
    logic [DATA_WIDTH-1:0]   m0_rdata_q, m1_rdata_q;

    logic                    grant_sel;
    logic                    accept;
    logic                    rsp_fire_d;
    logic [DATA_WIDTH-1:0]   rsp_data_d;

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    function automatic logic [DATA_WIDTH-1:0] timeout_pattern();
        logic [31:0]           pat;
        logic [DATA_WIDTH-1:0] r;
        pat = 32'hFEE1DEAD;
        r   = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            r[i] = pat[i % 32];
        end
        return r;
    endfunction

    logic [CNT_W-1:0] cnt_q;
    logic             m0_err_q, m1_err_q;
    logic             rsp_err_d;
`endif

    // Round-robin: a tie goes to the requester that was not granted last.
    // Gating with reset keeps ready low while reset is asserted.
    always_comb begin
        grant_sel = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            grant_sel = ~last_grant_q;
        end else if (m1_req_valid) begin
            grant_sel = 1'b1;
        end
        accept = (state_q == S_IDLE) && !reset && (m0_req_valid || m1_req_valid);
    end

    assign m0_req_ready = accept && !grant_sel;
    assign m1_req_ready = accept &&  grant_sel;

    // WAIT exit condition and the payload delivered to the granted requester.
    // When the bus responds in the same cycle that the timer expires, the bus wins.
    always_comb begin
        rsp_fire_d = 1'b0;
        rsp_data_d = bus_rsp_rdata;
`ifdef REG_ARB_TIMEOUT_EN
        rsp_err_d  = 1'b0;
`endif
        if (state_q == S_WAIT) begin
            if (bus_rsp_valid) begin
                rsp_fire_d = 1'b1;
`ifdef REG_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                rsp_fire_d = 1'b1;
                rsp_data_d = timeout_pattern();
                rsp_err_d  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            last_grant_q    <= 1'b1;
            grant_q         <= 1'b0;
            bus_req_valid_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_wr_q        <= 1'b0;
            bus_wdata_q     <= '0;
            bus_wstrb_q     <= '0;
            m0_rsp_valid_q  <= 1'b0;
            m1_rsp_valid_q  <= 1'b0;
            m0_rdata_q      <= '0;
            m1_rdata_q      <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            cnt_q           <= '0;
            m0_err_q        <= 1'b0;
            m1_err_q        <= 1'b0;
`endif
        end else begin
            bus_req_valid_q <= 1'b0;
            m0_rsp_valid_q  <= 1'b0;
            m1_rsp_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        grant_q         <= grant_sel;
                        bus_addr_q      <= grant_sel ? m1_req_addr  : m0_req_addr;
                        bus_wr_q        <= grant_sel ? m1_req_wr    : m0_req_wr;
                        bus_wdata_q     <= grant_sel ? m1_req_wdata : m0_req_wdata;
                        bus_wstrb_q     <= grant_sel ? m1_req_wstrb : m0_req_wstrb;
                        bus_req_valid_q <= 1'b1;
                        state_q         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (rsp_fire_d) begin
                        // The response is loaded straight into the granted
                        // requester's holding registers, so the pulse and its
                        // data appear together during RESP.
                        if (grant_q) begin
                            m1_rsp_valid_q <= 1'b1;
                            m1_rdata_q     <= rsp_data_d;
`ifdef REG_ARB_TIMEOUT_EN
                            m1_err_q       <= rsp_err_d;
`endif
                        end else begin
                            m0_rsp_valid_q <= 1'b1;
                            m0_rdata_q     <= rsp_data_d;
`ifdef REG_ARB_TIMEOUT_EN
                            m0_err_q       <= rsp_err_d;
`endif
                        end
                        state_q <= S_RESP;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    cnt_q <= rsp_fire_d ? '0 : cnt_q + 1'b1;
`endif
                end
                S_RESP: begin
                    last_grant_q <= grant_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_req_valid = bus_req_valid_q;
    assign bus_req_addr  = bus_addr_q;
    assign bus_req_wr    = bus_wr_q;
    assign bus_req_wdata = bus_wdata_q;
    assign bus_req_wstrb = bus_wstrb_q;
    assign m0_rsp_valid  = m0_rsp_valid_q;
    assign m1_rsp_valid  = m1_rsp_valid_q;
    assign m0_rsp_rdata  = m0_rdata_q;
    assign m1_rsp_rdata  = m1_rdata_q;
`ifdef REG_ARB_TIMEOUT_EN
    assign m0_rsp_err    = m0_err_q;
    assign m1_rsp_err    = m1_err_q;
`else
    assign m0_rsp_err    = 1'b0;
    assign m1_rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_reg_access_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_access_arbiter
//
// Directed self-checking bench for reg_access_arbiter. Inputs are driven 1ns
// after the rising edge. Registered outputs are sampled at that point.
// Combinational ready is sampled 1ns later, after the new inputs have settled.
// Timeout scenarios compile only when REG_ARB_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------
module tb_reg_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req_valid, m0_req_ready, m0_req_wr, m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic [3:0]  m0_req_wstrb;
    logic        m1_req_valid, m1_req_ready, m1_req_wr, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [3:0]  m1_req_wstrb;
    logic        bus_req_valid, bus_req_wr, bus_rsp_valid;
    logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
    logic [3:0]  bus_req_wstrb;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_access_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wr    (m0_req_wr),
        .m0_req_wdata (m0_req_wdata),
        .m0_req_wstrb (m0_req_wstrb),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wr    (m1_req_wr),
        .m1_req_wdata (m1_req_wdata),
        .m1_req_wstrb (m1_req_wstrb),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .m1_rsp_err   (m1_rsp_err),
        .bus_req_valid(bus_req_valid),
        .bus_req_addr (bus_req_addr),
        .bus_req_wr   (bus_req_wr),
        .bus_req_wdata(bus_req_wdata),
        .bus_req_wstrb(bus_req_wstrb),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_m0_ready"}, m0_req_ready,  0);
        check({pfx, "_m1_ready"}, m1_req_ready,  0);
        check({pfx, "_m0_rsp_v"}, m0_rsp_valid,  0);
        check({pfx, "_m1_rsp_v"}, m1_rsp_valid,  0);
        check({pfx, "_m0_rdata"}, m0_rsp_rdata,  0);
        check({pfx, "_m1_rdata"}, m1_rsp_rdata,  0);
        check({pfx, "_m0_err"},   m0_rsp_err,    0);
        check({pfx, "_m1_err"},   m1_rsp_err,    0);
        check({pfx, "_bus_v"},    bus_req_valid, 0);
        check({pfx, "_bus_addr"}, bus_req_addr,  0);
        check({pfx, "_bus_wr"},   bus_req_wr,    0);
        check({pfx, "_bus_wd"},   bus_req_wdata, 0);
        check({pfx, "_bus_ws"},   bus_req_wstrb, 0);
    endtask

    // Wait (bounded) for a grant with requests already driven. The bus then
    // responds one cycle after issue, which is the minimum-latency path.
    // The caller must be at 1ns after an edge.
    task automatic serve(input string tag, input logic exp_m1, input logic [31:0] data);
        int waited = 0;
        #1;
        while (!(m0_req_ready || m1_req_ready) && waited < 10) begin
            step();
            #1;
            waited++;
        end
        check({tag, "_grant_seen"}, waited < 10, 1);
        check({tag, "_two_ready"},  m0_req_ready && m1_req_ready, 0);
        check({tag, "_grant_m1"},   m1_req_ready, exp_m1);
        step();                                   // ISSUE
        check({tag, "_issue"}, bus_req_valid, 1);
        step();                                   // WAIT
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = data;
        step();                                   // RESP
        bus_rsp_valid = 1'b0;
        check({tag, "_m0_rsp_v"}, m0_rsp_valid, !exp_m1);
        check({tag, "_m1_rsp_v"}, m1_rsp_valid, exp_m1);
        check({tag, "_rdata"}, exp_m1 ? m1_rsp_rdata : m0_rsp_rdata, data);
        #1;
        check({tag, "_resp_no_ready"}, m0_req_ready || m1_req_ready, 0);
        step();                                   // IDLE
    endtask

    initial begin
        reset         = 1'b1;
        m0_req_valid  = 1'b0; m0_req_addr = '0; m0_req_wr = 1'b0;
        m0_req_wdata  = '0;   m0_req_wstrb = '0;
        m1_req_valid  = 1'b0; m1_req_addr = '0; m1_req_wr = 1'b0;
        m1_req_wdata  = '0;   m1_req_wstrb = '0;
        bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;

        // Reset state
        step(); step();
        check_all_zero("rst");
        reset = 1'b0;
        step();

        // Single m0 read: the bus answers two cycles after issue.
        m0_req_valid = 1'b1; m0_req_addr = 32'h10; m0_req_wr = 1'b0;
        #1;
        t0 = cyc;
        check("rd_m0_ready", m0_req_ready, 1);
        check("rd_m1_ready", m1_req_ready, 0);
        step();                                   // T+1 ISSUE
        m0_req_valid = 1'b0;
        check("rd_bus_v",    bus_req_valid, 1);
        check("rd_bus_addr", bus_req_addr,  32'h10);
        check("rd_bus_wr",   bus_req_wr,    0);
        step();                                   // T+2 WAIT
        check("rd_bus_v_pulse", bus_req_valid, 0);
        step();                                   // T+3
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1234;
        step();                                   // T+4 RESP
        bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        check("rd_rsp_v",    m0_rsp_valid, 1);
        check("rd_rsp_data", m0_rsp_rdata, 32'h1234);
        check("rd_rsp_err",  m0_rsp_err,   0);
        check("rd_m1_quiet", m1_rsp_valid, 0);
        check("rd_latency",  cyc - t0,     4);
        step();
        check("rd_rsp_once", m0_rsp_valid, 0);
        check("rd_rsp_hold", m0_rsp_rdata, 32'h1234);

        // m1 write
        m1_req_valid = 1'b1; m1_req_addr = 32'h20; m1_req_wr = 1'b1;
        m1_req_wdata = 32'hA5A5_A5A5; m1_req_wstrb = 4'hF;
        #1;
        check("wr_m1_ready", m1_req_ready, 1);
        check("wr_m0_ready", m0_req_ready, 0);
        step();                                   // ISSUE
        m1_req_valid = 1'b0; m1_req_addr = 32'hDEAD; m1_req_wdata = '0; m1_req_wstrb = '0;
        check("wr_bus_v",    bus_req_valid, 1);
        check("wr_bus_wr",   bus_req_wr,    1);
        check("wr_bus_wd",   bus_req_wdata, 32'hA5A5_A5A5);
        check("wr_bus_ws",   bus_req_wstrb, 4'hF);
        step();                                   // WAIT
        check("wr_addr_stable", bus_req_addr, 32'h20);
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hA5A5_A5A5;
        step();                                   // RESP
        bus_rsp_valid = 1'b0;
        check("wr_m1_rsp_v",  m1_rsp_valid, 1);
        check("wr_m1_rdata",  m1_rsp_rdata, 32'hA5A5_A5A5);
        check("wr_m0_no_rsp", m0_rsp_valid, 0);
        check("wr_m0_hold",   m0_rsp_rdata, 32'h1234);
        step();
        check("wr_m1_once",   m1_rsp_valid, 0);

        // A bus response while IDLE is ignored and the FSM stays in IDLE.
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h5555;
        step();
        bus_rsp_valid = 1'b0;
        check("idle_rsp_m0", m0_rsp_valid, 0);
        check("idle_rsp_m1", m1_rsp_valid, 0);
        step();
        check("idle_rsp_m0b",   m0_rsp_valid, 0);
        check("idle_rsp_rdata", m0_rsp_rdata, 32'h1234);
        m0_req_valid = 1'b1; m0_req_addr = 32'h30; m0_req_wr = 1'b0;
        #1;
        check("idle_still_idle", m0_req_ready, 1);
        step();
        m0_req_valid = 1'b0;
        step();                                   // WAIT
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h0BAD_F00D;
        step();
        bus_rsp_valid = 1'b0;
        check("idle_after_rsp", m0_rsp_rdata, 32'h0BAD_F00D);
        step();

        // Reset during WAIT abandons the access.
        m0_req_valid = 1'b1; m0_req_addr = 32'h40;
        step();                                   // ISSUE
        m0_req_valid = 1'b0;
        step();                                   // WAIT
        reset = 1'b1;
        step();
        check_all_zero("rstw");
        reset = 1'b0;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h7777;
        step();
        bus_rsp_valid = 1'b0;
        check("rstw_no_rsp0", m0_rsp_valid, 0);
        step();
        check("rstw_no_rsp1", m0_rsp_valid, 0);
        m0_req_valid = 1'b1; m0_req_addr = 32'h44;
        serve("rstw_next", 1'b0, 32'hCAFE_0001);
        m0_req_valid = 1'b0;

        // Both requesters continuously valid from reset: grants alternate.
        reset = 1'b1;
        m0_req_valid = 1'b1; m1_req_valid = 1'b1;
        m0_req_wr = 1'b0; m1_req_wr = 1'b0;
        step();
        #1;
        check("rr_rst_no_ready", m0_req_ready || m1_req_ready, 0);
        step();
        reset = 1'b0;
        serve("rr0", 1'b0, 32'h100);
        serve("rr1", 1'b1, 32'h101);
        serve("rr2", 1'b0, 32'h102);
        serve("rr3", 1'b1, 32'h103);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        step();

`ifdef REG_ARB_TIMEOUT_EN
        // Bus silent: the response arrives after 8 WAIT cycles (accept T, RESP T+10).
        m0_req_valid = 1'b1; m0_req_addr = 32'h50;
        #1;
        t0 = cyc;
        check("to_ready", m0_req_ready, 1);
        step();
        m0_req_valid = 1'b0;
        for (int i = 0; i < 20 && !m0_rsp_valid; i++) step();
        check("to_rsp_v",   m0_rsp_valid, 1);
        check("to_latency", cyc - t0,     10);
        check("to_rdata",   m0_rsp_rdata, 32'hFEE1_DEAD);
        check("to_err",     m0_rsp_err,   1);
        step();
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1111;
        step();
        bus_rsp_valid = 1'b0;
        check("to_late_ign", m0_rsp_valid, 0);
        step();
        check("to_late_ign2", m0_rsp_valid, 0);
        check("to_err_hold",  m0_rsp_err,   1);

        // Bus response in the expiry cycle wins over the timeout.
        m0_req_valid = 1'b1;
        #1;
        t0 = cyc;
        step();
        m0_req_valid = 1'b0;
        while (cyc < t0 + 9) step();              // 8th WAIT cycle
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h2222;
        step();
        bus_rsp_valid = 1'b0;
        check("to_race_v",     m0_rsp_valid, 1);
        check("to_race_rdata", m0_rsp_rdata, 32'h2222);
        check("to_race_err",   m0_rsp_err,   0);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
